alu_op_sequencer: RTL

//  Initiator for the 8-bit ALU operand interface (A, B, s -> y, carry).

---
 rtl/alu_op_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Drives one latched operand pair through every opcode OP_FIRST..OP_LAST of an 8-bit ALU
// and streams each result out over valid/ready. Optional signature fold: define ALUSEQ_SIG_EN.
module alu_op_sequencer #(
    parameter int         WIDTH    = 8,
    parameter logic [2:0] OP_FIRST = 3'd0,
    parameter logic [2:0] OP_LAST  = 3'd7,
    parameter int         SETTLE   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_s,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2:0]       res_op,
    output logic [WIDTH-1:0] res_y,
    output logic             res_carry,
    output logic             done,
    output logic [15:0]      sig
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RESULT
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_s_q, alu_s_d;
    logic             res_valid_q, res_valid_d;
    logic [2:0]       res_op_q, res_op_d;
    logic [WIDTH-1:0] res_y_q, res_y_d;
    logic             res_carry_q, res_carry_d;
    logic             done_q, done_d;
    logic             handshake;
    logic             accept;

    assign accept    = (state_q == S_IDLE) && start;
    assign handshake = (state_q == S_RESULT) && res_valid_q && res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            res_valid_q <= 1'b0;
            res_op_q    <= '0;
            res_y_q     <= '0;
            res_carry_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_s_q     <= alu_s_d;
            res_valid_q <= res_valid_d;
            res_op_q    <= res_op_d;
            res_y_q     <= res_y_d;
            res_carry_q <= res_carry_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_s_d     = alu_s_q;
        res_valid_d = res_valid_q;
        res_op_d    = res_op_q;
        res_y_d     = res_y_q;
        res_carry_d = res_carry_q;
        done_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_a_d = a_in;
                    alu_b_d = b_in;
                    alu_s_d = OP_FIRST;
                    cnt_d   = CNT_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // The ALU is combinational; its output has settled once cnt reaches zero.
                if (cnt_q == 4'd0) begin
                    res_y_d     = alu_y;
                    res_carry_d = alu_carry;
                    res_op_d    = alu_s_q;
                    res_valid_d = 1'b1;
                    state_d     = S_RESULT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESULT: begin
                if (handshake) begin
                    res_valid_d = 1'b0;
                    if (alu_s_q == OP_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        alu_s_d = alu_s_q + 3'd1;
                        cnt_d   = CNT_LOAD;
                        state_d = S_SETTLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign res_valid = res_valid_q;
    assign res_op    = res_op_q;
    assign res_y     = res_y_q;
    assign res_carry = res_carry_q;
    assign done      = done_q;

`ifdef ALUSEQ_SIG_EN
    logic [15:0] sig_q, sig_d, fold_word;

    always_comb begin
        fold_word              = '0;
        fold_word[WIDTH:0]     = {res_carry_q, res_y_q};
        sig_d                  = sig_q;
        if (accept) begin
            sig_d = '0;
        end else if (handshake) begin
            sig_d = {sig_q[14:0], sig_q[15]} ^ fold_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`else
    assign sig = 16'h0000;
`endif

endmodule
